// File: rtl/signal_analyser_frame.sv
// signal_analyser_frame
//   Per-channel audio analyser running on one system clock with a sample strobe.
//   Pitch path: hysteretic rising-zero-crossing detector, period counter in
//   samples, and band classification (low / mid / high / timeout).
//   Volume path: peak magnitude over a frame of FRAME_LEN samples, reported
//   with a 4-level volume code at the end of every frame.
//
// Ports
//   clk         in   system clock, all state changes on posedge
//   resetn      in   synchronous active-low reset (overrides read_ready)
//   left        in   signed sample, valid when read_ready=1
//   read_ready  in   sample strobe, one sample per high cycle
//   pitch       out  00 low, 01 mid, 10 high, 11 none/timeout
//   pitch_valid out  one-cycle pulse when pitch is updated
//   volume      out  volume code of the last completed frame
//   peak        out  peak magnitude of the last completed frame
//   frame_done  out  one-cycle pulse when volume/peak are updated
module signal_analyser_frame #(
   parameter int DATA_W     = 24,
   parameter int CNT_W      = 15,
   parameter int FRAME_LEN  = 800,
   parameter int HYST       = 4096,
   parameter int LOW_BOUND  = 60,
   parameter int HIGH_BOUND = 120
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic signed [DATA_W-1:0] left,
   input  logic                     read_ready,
   output logic [1:0]               pitch,
   output logic                     pitch_valid,
   output logic [1:0]               volume,
   output logic [DATA_W-1:0]        peak,
   output logic                     frame_done
);

   localparam int FCNT_W = $clog2(FRAME_LEN);

   localparam logic signed [DATA_W-1:0] HYST_POS = DATA_W'(HYST);
   localparam logic signed [DATA_W-1:0] HYST_NEG = -HYST_POS;
   localparam logic signed [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic [DATA_W-1:0]        MAG_MAX  = {1'b0, {(DATA_W-1){1'b1}}};

   localparam logic [DATA_W-1:0] VOL3_TH = DATA_W'(1) << (DATA_W-2);
   localparam logic [DATA_W-1:0] VOL2_TH = DATA_W'(1) << (DATA_W-3);
   localparam logic [DATA_W-1:0] VOL1_TH = DATA_W'(1) << (DATA_W-4);

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_NEAR = CNT_MAX - CNT_ONE;
   localparam logic [CNT_W:0]   LOW_P    = (CNT_W+1)'(LOW_BOUND);
   localparam logic [CNT_W:0]   HIGH_P   = (CNT_W+1)'(HIGH_BOUND);

   localparam logic [FCNT_W-1:0] FCNT_ONE  = FCNT_W'(1);
   localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FRAME_LEN-1);

   typedef enum logic {NEG = 1'b0, POS = 1'b1} xing_t;

   // Magnitude with the most negative code saturated to the largest positive.
   function automatic logic [DATA_W-1:0] sat_mag(input logic signed [DATA_W-1:0] x);
      if (!x[DATA_W-1])
         sat_mag = $unsigned(x);
      else if (x == MOST_NEG)
         sat_mag = MAG_MAX;
      else
         sat_mag = $unsigned(-x);
   endfunction

   function automatic logic [1:0] vol_code(input logic [DATA_W-1:0] pk);
      if (pk >= VOL3_TH)
         vol_code = 2'b11;
      else if (pk >= VOL2_TH)
         vol_code = 2'b10;
      else if (pk >= VOL1_TH)
         vol_code = 2'b01;
      else
         vol_code = 2'b00;
   endfunction

   function automatic logic [1:0] band(input logic [CNT_W:0] p);
      if (p > HIGH_P)
         band = 2'b00;
      else if (p >= LOW_P)
         band = 2'b01;
      else
         band = 2'b10;
   endfunction

   xing_t               state;
   logic [CNT_W-1:0]    cnt;
   logic                armed;
   logic [FCNT_W-1:0]   fcnt;
   logic [DATA_W-1:0]   runmax;

   logic [1:0]          pitch_p1;
   logic                pitch_vld_p1;
   logic [1:0]          volume_p1;
   logic [DATA_W-1:0]   peak_p1;
   logic                frame_vld_p1;

   // Stage 0: combinational view of the incoming sample
   logic [DATA_W-1:0]   mag_p0;
   logic [DATA_W-1:0]   pk_p0;
   logic                rise_p0;
   logic [CNT_W:0]      period_p0;

   always_comb begin
      mag_p0    = sat_mag(left);
      pk_p0     = (mag_p0 > runmax) ? mag_p0 : runmax;
      rise_p0   = (state == NEG) && (left >= HYST_POS);
      // One bit wider so a saturated counter still yields 2^CNT_W.
      period_p0 = {1'b0, cnt} + (CNT_W+1)'(1);
   end

   // Stage 1: registered state and outputs
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state        <= NEG;
         cnt          <= '0;
         armed        <= 1'b0;
         fcnt         <= '0;
         runmax       <= '0;
         pitch_p1     <= 2'b11;
         pitch_vld_p1 <= 1'b0;
         volume_p1    <= 2'b00;
         peak_p1      <= '0;
         frame_vld_p1 <= 1'b0;
      end else begin
         pitch_vld_p1 <= 1'b0;
         frame_vld_p1 <= 1'b0;
         if (read_ready) begin
            case (state)
               NEG:     if (left >= HYST_POS) state <= POS;
               POS:     if (left <= HYST_NEG) state <= NEG;
               default: state <= NEG;
            endcase

            // A crossing takes priority over a simultaneous saturation.
            if (rise_p0) begin
               cnt   <= '0;
               armed <= 1'b1;
               if (armed) begin
                  pitch_p1     <= band(period_p0);
                  pitch_vld_p1 <= 1'b1;
               end
            end else if (cnt != CNT_MAX) begin
               cnt <= cnt + CNT_ONE;
               if (cnt == CNT_NEAR) begin
                  pitch_p1     <= 2'b11;
                  pitch_vld_p1 <= 1'b1;
                  armed        <= 1'b0;
               end
            end

            if (fcnt == FCNT_LAST) begin
               fcnt         <= '0;
               runmax       <= '0;
               peak_p1      <= pk_p0;
               volume_p1    <= vol_code(pk_p0);
               frame_vld_p1 <= 1'b1;
            end else begin
               fcnt   <= fcnt + FCNT_ONE;
               runmax <= pk_p0;
            end
         end
      end
   end

   assign pitch       = pitch_p1;
   assign pitch_valid = pitch_vld_p1;
   assign volume      = volume_p1;
   assign peak        = peak_p1;
   assign frame_done  = frame_vld_p1;

endmodule

// File: tb/tb_signal_analyser_frame.sv
// Testbench for signal_analyser_frame (FRAME_LEN overridden to 8).
// A behavioural model tracks sample indices of rising crossings and a queue of
// frame magnitudes; every clock all outputs are compared against it. A table of
// frame vectors and directed sequences add hand-computed expectations.
module tb_signal_analyser_frame;
   localparam int DATA_W     = 24;
   localparam int CNT_W      = 15;
   localparam int FRAME_LEN  = 8;
   localparam int HYST       = 4096;
   localparam int LOW_BOUND  = 60;
   localparam int HIGH_BOUND = 120;
   localparam int AMP        = 'h100000;
   localparam int MAG_MAX    = (1 << (DATA_W-1)) - 1;
   localparam longint CNT_SAT = (longint'(1) << CNT_W) - 1;

   logic                     clk = 1'b0;
   logic                     resetn = 1'b0;
   logic                     read_ready = 1'b0;
   logic signed [DATA_W-1:0] left = '0;
   logic [1:0]               pitch;
   logic                     pitch_valid;
   logic [1:0]               volume;
   logic [DATA_W-1:0]        peak;
   logic                     frame_done;

   signal_analyser_frame #(
      .DATA_W(DATA_W), .CNT_W(CNT_W), .FRAME_LEN(FRAME_LEN),
      .HYST(HYST), .LOW_BOUND(LOW_BOUND), .HIGH_BOUND(HIGH_BOUND)
   ) dut (
      .clk(clk), .resetn(resetn), .left(left), .read_ready(read_ready),
      .pitch(pitch), .pitch_valid(pitch_valid), .volume(volume),
      .peak(peak), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // reference model state
   bit                m_pos;
   bit                m_armed;
   longint            m_i;
   longint            m_last;
   int                m_mags[$];
   logic [1:0]        e_pitch = 2'b11;
   logic              e_pv = 1'b0;
   logic [1:0]        e_vol = 2'b00;
   logic [DATA_W-1:0] e_peak = '0;
   logic              e_fd = 1'b0;
   logic [1:0]        pulses[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   function automatic int mag_of(input int s);
      int m;
      m = (s < 0) ? -s : s;
      return (m > MAG_MAX) ? MAG_MAX : m;
   endfunction

   function automatic logic [1:0] vol_of(input int pk);
      if (pk >= (1 << (DATA_W-2))) return 2'b11;
      if (pk >= (1 << (DATA_W-3))) return 2'b10;
      if (pk >= (1 << (DATA_W-4))) return 2'b01;
      return 2'b00;
   endfunction

   task automatic model_reset();
      m_pos = 1'b0; m_armed = 1'b0; m_i = 0; m_last = 0;
      m_mags.delete();
      e_pitch = 2'b11; e_vol = 2'b00; e_peak = '0;
   endtask

   // Sample indices count from 1 after reset; reset acts as a crossing at index 0
   // for the purpose of the period counter.
   task automatic model_sample(input int s);
      bit     rise;
      longint p;
      int     pk;
      rise = 1'b0;
      m_i++;
      if (!m_pos && s >= HYST) begin
         m_pos = 1'b1; rise = 1'b1;
      end else if (m_pos && s <= -HYST) begin
         m_pos = 1'b0;
      end
      if (rise) begin
         p = m_i - m_last;
         if (p > CNT_SAT + 1) p = CNT_SAT + 1;
         if (m_armed) begin
            e_pv = 1'b1;
            e_pitch = (p > HIGH_BOUND) ? 2'b00 : (p >= LOW_BOUND) ? 2'b01 : 2'b10;
         end
         m_armed = 1'b1;
         m_last = m_i;
      end else if (m_i - m_last == CNT_SAT) begin
         e_pv = 1'b1; e_pitch = 2'b11; m_armed = 1'b0;
      end
      m_mags.push_back(mag_of(s));
      if (m_mags.size() == FRAME_LEN) begin
         pk = 0;
         foreach (m_mags[j]) if (m_mags[j] > pk) pk = m_mags[j];
         e_fd = 1'b1; e_peak = pk[DATA_W-1:0]; e_vol = vol_of(pk);
         m_mags.delete();
      end
   endtask

   task automatic cycle(input logic rn, input logic rr, input int s);
      resetn = rn; read_ready = rr; left = s[DATA_W-1:0];
      @(posedge clk);
      e_pv = 1'b0; e_fd = 1'b0;
      if (!rn) model_reset();
      else if (rr) model_sample(s);
      #1;
      check("pitch", {30'd0, pitch}, {30'd0, e_pitch});
      check("pitch_valid", {31'd0, pitch_valid}, {31'd0, e_pv});
      check("volume", {30'd0, volume}, {30'd0, e_vol});
      check("peak", {8'd0, peak}, {8'd0, e_peak});
      check("frame_done", {31'd0, frame_done}, {31'd0, e_fd});
      if (pitch_valid === 1'b1) pulses.push_back(pitch);
   endtask

   task automatic sample(input int s, input int gap);
      cycle(1'b1, 1'b1, s);
      for (int g = 0; g < gap; g++)
         cycle(1'b1, 1'b0, int'($urandom_range(0, 16777215)) - 8388608);
   endtask

   task automatic square(input int period, input int gap);
      for (int k = 0; k < period; k++)
         sample((k < period/2) ? AMP : -AMP, gap);
   endtask

   task automatic check_pulses(input string name, input int n, input logic [9:0] exp);
      logic [1:0] got;
      check({name, "_count"}, pulses.size(), n);
      for (int i = 0; i < n; i++) begin
         got = 2'bxx;
         if (i < pulses.size()) got = pulses[i];
         check(name, {30'd0, got}, {30'd0, exp[2*i +: 2]});
      end
   endtask

   typedef struct {
      int                s;
      logic              fd;
      logic [1:0]        vol;
      logic [DATA_W-1:0] pk;
   } vec_t;

   vec_t tbl[40];
   int                big[5]     = '{-2097151, 2097152, 4194304, -8388608, 16};
   int                pos[5]     = '{0, 7, 3, 3, 5};
   logic [1:0]        exp_vol[5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd0};
   logic [DATA_W-1:0] exp_pk[5]  = '{24'h1FFFFF, 24'h200000, 24'h400000, 24'h7FFFFF, 24'h000010};

   initial begin
      logic [1:0]        pv;
      logic [DATA_W-1:0] pp;
      int                per, amp, s;

      // frame vector table: one large sample per frame among small fillers
      pv = 2'b00; pp = '0;
      for (int f = 0; f < 5; f++) begin
         for (int k = 0; k < FRAME_LEN; k++) begin
            tbl[f*FRAME_LEN + k].s   = (k == pos[f]) ? big[f] : ((k % 2) != 0 ? -3 : 7);
            tbl[f*FRAME_LEN + k].fd  = (k == FRAME_LEN-1);
            tbl[f*FRAME_LEN + k].vol = (k == FRAME_LEN-1) ? exp_vol[f] : pv;
            tbl[f*FRAME_LEN + k].pk  = (k == FRAME_LEN-1) ? exp_pk[f] : pp;
         end
         pv = exp_vol[f]; pp = exp_pk[f];
      end

      // reset state
      model_reset();
      cycle(1'b0, 1'b1, AMP);
      cycle(1'b0, 1'b0, 0);
      check("rst_pitch", {30'd0, pitch}, 32'd3);
      check("rst_pitch_valid", {31'd0, pitch_valid}, 32'd0);
      check("rst_volume", {30'd0, volume}, 32'd0);
      check("rst_peak", {8'd0, peak}, 32'd0);
      check("rst_frame_done", {31'd0, frame_done}, 32'd0);

      // volume frames from the table
      for (int i = 0; i < 40; i++) begin
         cycle(1'b1, 1'b1, tbl[i].s);
         check("tbl_frame_done", {31'd0, frame_done}, {31'd0, tbl[i].fd});
         check("tbl_volume", {30'd0, volume}, {30'd0, tbl[i].vol});
         check("tbl_peak", {8'd0, peak}, {8'd0, tbl[i].pk});
      end

      // mid band, continuous strobe
      cycle(1'b0, 1'b1, 0);
      pulses.delete();
      for (int r = 0; r < 4; r++) square(100, 0);
      sample(AMP, 0);
      check_pulses("mid_band", 4, 10'b00_01_01_01_01);

      // band boundaries: 59, 60, 120, 121
      cycle(1'b0, 1'b1, 0);
      pulses.delete();
      square(100, 0); square(59, 0); square(60, 0); square(120, 0); square(121, 0);
      sample(AMP, 0);
      check_pulses("bands", 5, 10'b00_01_01_10_01);

      // sparse strobe, every third cycle
      cycle(1'b0, 1'b1, 0);
      pulses.delete();
      for (int r = 0; r < 4; r++) square(100, 2);
      sample(AMP, 2);
      check_pulses("sparse", 4, 10'b00_01_01_01_01);

      // reset mid-frame and mid-period
      cycle(1'b0, 1'b1, 0);
      square(100, 0); square(100, 0);
      for (int k = 0; k < 5; k++) sample(AMP, 0);
      check("pre_reset_pitch", {30'd0, pitch}, 32'd1);
      cycle(1'b0, 1'b1, AMP);
      check("mid_rst_pitch", {30'd0, pitch}, 32'd3);
      check("mid_rst_volume", {30'd0, volume}, 32'd0);
      check("mid_rst_peak", {8'd0, peak}, 32'd0);
      pulses.delete();
      for (int k = 0; k < FRAME_LEN; k++) begin
         sample(-AMP, 0);
         check("post_rst_frame_done", {31'd0, frame_done}, (k == FRAME_LEN-1) ? 32'd1 : 32'd0);
      end
      for (int k = 0; k < 12; k++) sample(-AMP, 0);
      square(100, 0); square(100, 0);
      sample(AMP, 0);
      check_pulses("post_rst_arm", 2, 10'b00_00_00_01_01);

      // hysteresis: small triangle never crosses, single timeout
      cycle(1'b0, 1'b1, 0);
      pulses.delete();
      for (int k = 0; k < 32767 + 200; k++)
         sample(((k % 64) - 32) * 64, 0);
      check_pulses("timeout", 1, 10'b00_00_00_00_11);
      check("timeout_pitch", {30'd0, pitch}, 32'd3);

      // crossing on the sample that would saturate: arms, no timeout
      cycle(1'b0, 1'b1, 0);
      pulses.delete();
      for (int k = 0; k < 32766; k++) sample(-AMP, 0);
      sample(AMP, 0);
      sample(-AMP, 0);
      sample(AMP, 0);
      check_pulses("cross_vs_sat", 1, 10'b00_00_00_00_10);

      // randomized stimulus against the model
      cycle(1'b0, 1'b1, 0);
      for (int seg = 0; seg < 80; seg++) begin
         per = $urandom_range(4, 200);
         amp = ($urandom_range(0, 3) == 0) ? $urandom_range(3000, 5000) : $urandom_range(4096, 8388607);
         for (int k = 0; k < per; k++) begin
            s = (k < per/2) ? amp : -amp;
            if ($urandom_range(0, 15) == 0) s = int'($urandom_range(0, 16777215)) - 8388608;
            if ($urandom_range(0, 63) == 0) s = -8388608;
            cycle(1'b1, ($urandom_range(0, 3) != 0), s);
         end
         if ($urandom_range(0, 9) == 0) cycle(1'b0, $urandom_range(0, 1) != 0, AMP);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, checks %0d", n_checks);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/signal_analyser_frame.md
# signal_analyser_frame

Parametrised successor to the per-channel pitch/volume analyser in the audio front end. It sits between the audio codec sample interface and the game logic, and uses one clock with a sample strobe instead of separate sample and 60 Hz clocks.

- **Pitch:** measures the waveform period in samples between rising zero crossings, with hysteresis, and classifies it into bands.
- **Volume:** tracks peak magnitude over a fixed frame of FRAME_LEN samples, then reports the frame peak and a 4-level volume code.

## Interface
Parameters:
- DATA_W, 24, sample width (signed two's complement)
- CNT_W, 15, period counter width
- FRAME_LEN, 800, samples per volume frame (800 = 48 kHz / 60); must be ≥ 2
- HYST, 4096, zero-crossing hysteresis magnitude
- LOW_BOUND, 60, period at or above which pitch is not "high"
- HIGH_BOUND, 120, period above which pitch is "low"

Ports:
- clk  in  1  single system clock; all state changes on posedge
- resetn  in  1  synchronous, active-low reset
- left  in  DATA_W  signed sample; valid only when read_ready=1
- read_ready  in  1  sample strobe; one sample accepted per cycle it is high
- pitch  out  2  00 low, 01 mid, 10 high, 11 none/timeout
- pitch_valid  out  1  one-cycle pulse when pitch is updated
- volume  out  2  level of last completed frame
- peak  out  DATA_W  peak magnitude of last completed frame
- frame_done  out  1  one-cycle pulse when volume/peak are updated

## Operation
- **Magnitude:** mag = left if left ≥ 0, else −left. The most negative value saturates to 2^(DATA_W−1)−1.
- **Crossing FSM:**
  - States: NEG (reset state) and POS.
  - NEG→POS when left ≥ +HYST. POS→NEG when left ≤ −HYST. Otherwise hold.
  - A rising crossing is the NEG→POS transition.
- **Period counter cnt** (CNT_W bits, reset 0), updated on accepted samples only:
  - On a rising crossing: P = cnt+1, then cnt ← 0.
  - Otherwise cnt ← cnt+1, saturating at 2^CNT_W−1.
- **Pitch classification:**
  - Only when armed. An armed flag is set by the first rising crossing after reset; that first crossing reports nothing.
  - P > HIGH_BOUND → 00.
  - LOW_BOUND ≤ P ≤ HIGH_BOUND → 01.
  - P < LOW_BOUND → 10.
- **Timeout:**
  - When cnt increments into saturation, pitch ← 11 with one pitch_valid pulse. Disarm.
  - The next rising crossing re-arms without reporting.
- **Simultaneous crossing and saturation:** the crossing wins; no timeout is reported.
- **Frame:**
  - fcnt runs 0..FRAME_LEN−1 on accepted samples and wraps to 0.
  - runmax ← max(runmax, mag).
  - On the sample with fcnt = FRAME_LEN−1: pk = max(runmax, mag), peak ← pk, runmax ← 0.
  - On that same sample, volume ← 11 if pk ≥ 2^(DATA_W−2); 10 if pk ≥ 2^(DATA_W−3); 01 if pk ≥ 2^(DATA_W−4); else 00.
- **Channels:** pitch and frame paths are independent. Both pulses may fire on the same cycle.

## Timing
- All outputs are registered. Latency is 1 cycle from an accepted read_ready cycle to the pitch/pitch_valid and volume/peak/frame_done updates.
- read_ready may be high on consecutive cycles; every such cycle is a sample.
- No state changes while read_ready=0.
- Pulses last exactly one cycle. Outputs hold their values between updates.
- **Reset, applied when resetn=0 at a posedge and overriding read_ready:**
  - pitch=11; pitch_valid=0; volume=00; peak=0; frame_done=0.
  - FSM=NEG; cnt=0; fcnt=0; runmax=0; armed=0.
- Reset mid-frame discards the partial frame.
- Reset mid-period discards the pending measurement; the next crossing only arms.

## Test plan
- **Mid band:** square wave, +0x100000 for 50 samples then −0x100000 for 50, on continuous read_ready. The first rising crossing gives no pulse. The second gives pitch=01, pitch_valid for 1 cycle, P=100; repeats every 100 samples.
- **Band boundaries:** periods 59, 60, 120, 121 → pitch 10, 01, 01, 00 respectively.
- **Hysteresis:** sine of amplitude 0x000800 (< HYST) around 0 → no crossings. After 32767 samples, pitch=11 with a single pitch_valid; no further pulses.
- **Volume:** FRAME_LEN=8 (override); peaks of 0x1FFFFF, 0x200000, 0x400000, and 0x800000 (→ 0x7FFFFF) in successive frames → volume 01, 10, 11, 11. Also check peak values, frame_done every 8th sample, and runmax cleared between frames.
- **Sparse strobe:** read_ready high every 3rd cycle, same stimulus as the mid-band case → identical pitch results. Outputs change only the cycle after a strobe.
- **Reset mid-operation:** drop resetn for 1 cycle at frame sample 5 and mid-period. All outputs return to reset values. The next frame_done comes FRAME_LEN samples later. The first post-reset crossing only arms.
